decode_cycle: RTL and testbench
===============================

// Module: decode_cycle
// PURPOSE
//  Decode stage of the 5-stage RV32I pipeline; consumer of the IF/ID register (InstrD, PCD, PCPlus4D) driven by fetch.
//  Holds the 32x32 register file, main/ALU control decoder and immediate generator.
//  Launches the ID/EX pipeline register.
//  Accepts writeback (W) writes; honours FlushE from the hazard unit.
// PARAMETERS
//  XLEN   32  datapath width; bit XLEN-1 is MSB, all vectors [XLEN-1:0]
//  NREG   32  register count, fixed at 32 (5-bit register addresses)
// PORTS
//  clk           in   1     system clock, rising edge
//  rst           in   1     reset; asynchronous, active-low
//  InstrD        in   XLEN  instruction from IF/ID
//  PCD           in   XLEN  PC of InstrD
//  PCPlus4D      in   XLEN  PCD+4
//  RegWriteW     in   1     writeback enable
//  RDW           in   5     writeback destination
//  ResultW       in   XLEN  writeback data
//  FlushE        in   1     sync flush of ID/EX (bubble insert)
//  Rs1D, Rs2D    out  5     InstrD[19:15], InstrD[24:20], combinational, for hazard unit
//  RegWriteE     out  1     | registered ID/EX control
//  ResultSrcE    out  2     | 00 ALU, 01 mem, 10 PC+4
//  MemWriteE     out  1     |
//  JumpE         out  1     |
//  BranchE       out  1     |
//  ALUControlE   out  3     | 000 add, 001 sub, 010 and, 011 or, 101 slt
//  ALUSrcE       out  1     | 1 = ImmExtE as operand B
//  RD1E, RD2E    out  XLEN  registered operands
//  ImmExtE       out  XLEN  registered sign-extended immediate
//  RdE,Rs1E,Rs2E out  5     registered register addresses
//  PCE, PCPlus4E out  XLEN  registered PCD, PCPlus4D
// BEHAVIOUR
//  Reset (rst=0, async): every E output = 0; all RF entries = 0. Reset wins over FlushE and RF writes.
//  RF write: rising clk, RegWriteW=1 and RDW!=0. RDW=0 writes are discarded; x0 always reads 0.
//  RF read: combinational. Same-cycle bypass: RegWriteW=1, RDW!=0 and RDW==Rs1D/Rs2D -> read returns ResultW.
//  Latency: InstrD sampled at edge N appears on E outputs after edge N, i.e. 1 cycle.
//  FlushE=1 at an edge: entire ID/EX register loads 0 (NOP bubble). The RF write still occurs.
//  No stall input: the hazard unit holds IF/ID; ID/EX reloads every cycle.
//  Main decode by opcode; fields RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump:
//   0110011 R      1 xx 0 0 00 0 10 0
//   0010011 I-ALU  1 00 1 0 00 0 10 0
//   0000011 lw     1 00 1 0 01 0 00 0
//   0100011 sw     0 01 1 1 00 0 00 0
//   1100011 beq    0 10 0 0 00 1 01 0
//   1101111 jal    1 11 0 0 10 0 00 1
//   Any other opcode: all controls 0.
//  ALU decode:
//   ALUOp 00 -> 000; ALUOp 01 -> 001.
//   ALUOp 10 by funct3: 000 -> 001 if {op[5],funct7[5]}==11, else 000; 010 -> 101; 110 -> 011; 111 -> 010; other -> 000.
//  Immediate generator:
//   I: {20{i31},i[31:20]}
//   S: {20{i31},i[31:25],i[11:7]}
//   B: {20{i31},i7,i[30:25],i[11:8],0}
//   J: {12{i31},i[19:12],i20,i[30:21],0}
// CONFIGURATION
//  DECODE_ILLEGAL_TRAP_EN defined:
//   Adds output IllegalE (1 bit, registered, reset 0, cleared by FlushE).
//   IllegalE=1 when the opcode is outside the table above or the R/I-ALU funct3 is unsupported; controls are 0 in that case.
//  DECODE_ILLEGAL_TRAP_EN undefined: no IllegalE port; unknown encodings decode silently to all-zero controls.
// TESTING
//  1 rst=0 mid-run after RF writes -> all E outputs 0 immediately; after release, read x5 -> RD1E=0.
//  2 RegWriteW=1,RDW=5,ResultW=0xDEADBEEF with InstrD=0x000280B3 (add x1,x5,x0) -> next edge RD1E=0xDEADBEEF (bypass), RdE=1, RegWriteE=1, ALUControlE=000.
//  3 InstrD=0xFFC1A103 (lw x2,-4(x3)) -> ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1, RdE=2, Rs1E=3.
//  4 InstrD=0xFE000CE3 (beq x0,x0,-8) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8, RegWriteE=0.
//  5 FlushE=1 with InstrD=0x000280B3 -> next edge all E outputs 0; an RF write in the same cycle still lands.
//  6 RegWriteW=1,RDW=0,ResultW=0x1234, then Rs1D=0 -> RD1E=0; PCD=0x40 -> PCE=0x40, PCPlus4E=0x44.

Source files
------------

// File: rtl/decode_cycle_if.sv
// Decode stage bus: IF/ID inputs, writeback port, flush, and the ID/EX
// register outputs. The IllegalE signal exists only when
// DECODE_ILLEGAL_TRAP_EN is defined.
interface decode_cycle_if #(
  parameter int XLEN = 32
);
  // IF/ID, writeback and hazard-unit inputs to decode
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            RegWriteW;
  logic [4:0]      RDW;
  logic [XLEN-1:0] ResultW;
  logic            FlushE;

  // Source register addresses for the hazard unit (combinational)
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;

  // ID/EX register
  logic            RegWriteE;
  logic [1:0]      ResultSrcE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic [2:0]      ALUControlE;
  logic            ALUSrcE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [4:0]      RdE;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic            IllegalE;
`endif

  // Pipeline side that feeds decode and consumes the ID/EX register
  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    input  Rs1D, Rs2D,
    input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
           ALUSrcE, RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E
`ifdef DECODE_ILLEGAL_TRAP_EN
    , IllegalE
`endif
  );

  // Decode stage itself
  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    output Rs1D, Rs2D,
    output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
           ALUSrcE, RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E
`ifdef DECODE_ILLEGAL_TRAP_EN
    , IllegalE
`endif
  );
endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: register file with same-cycle writeback bypass,
// main/ALU control decode, immediate generation and the ID/EX register.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN adds a registered IllegalE
// flag and forces controls to zero for unsupported encodings.
module decode_cycle #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic         clk,
  input logic         rst,
  decode_cycle_if.slave bus
);

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpIAlu = 7'b0010011;
  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;

  assign instr    = bus.InstrD;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];

  assign bus.Rs1D = rs1;
  assign bus.Rs2D = rs2;

  logic [XLEN-1:0] regFile [NREG];
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            wrValid;

  // Writes to x0 are dropped so entry 0 stays at its reset value
  assign wrValid = bus.RegWriteW && (bus.RDW != 5'd0);

  // Register file write port; reset clears every entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regFile[i] <= '0;
      end
    end else if (wrValid) begin
      regFile[bus.RDW] <= bus.ResultW;
    end
  end

  // Read ports: x0 is hardwired, a same-cycle writeback is forwarded
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != 5'd0) begin
      rd1 = (wrValid && bus.RDW == rs1) ? bus.ResultW : regFile[rs1];
    end
    if (rs2 != 5'd0) begin
      rd2 = (wrValid && bus.RDW == rs2) ? bus.ResultW : regFile[rs2];
    end
  end

  logic       regWriteD;
  logic [1:0] immSrcD;
  logic       aluSrcD;
  logic       memWriteD;
  logic [1:0] resultSrcD;
  logic       branchD;
  logic [1:0] aluOpD;
  logic       jumpD;

  // Main decoder; unlisted opcodes fall through to all-zero controls
  always_comb begin
    regWriteD  = 1'b0;
    immSrcD    = 2'b00;
    aluSrcD    = 1'b0;
    memWriteD  = 1'b0;
    resultSrcD = 2'b00;
    branchD    = 1'b0;
    aluOpD     = 2'b00;
    jumpD      = 1'b0;
    case (opcode)
      OpR: begin
        regWriteD = 1'b1;
        aluOpD    = 2'b10;
      end
      OpIAlu: begin
        regWriteD = 1'b1;
        aluSrcD   = 1'b1;
        aluOpD    = 2'b10;
      end
      OpLw: begin
        regWriteD  = 1'b1;
        aluSrcD    = 1'b1;
        resultSrcD = 2'b01;
      end
      OpSw: begin
        immSrcD   = 2'b01;
        aluSrcD   = 1'b1;
        memWriteD = 1'b1;
      end
      OpBeq: begin
        immSrcD = 2'b10;
        branchD = 1'b1;
        aluOpD  = 2'b01;
      end
      OpJal: begin
        regWriteD  = 1'b1;
        immSrcD    = 2'b11;
        resultSrcD = 2'b10;
        jumpD      = 1'b1;
      end
      default: ;
    endcase
  end

  logic [2:0] aluCtrlD;

  // ALU decoder; sub only for R-type with funct7[5] set (addi never subtracts)
  always_comb begin
    aluCtrlD = 3'b000;
    case (aluOpD)
      2'b01: aluCtrlD = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  aluCtrlD = ({opcode[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  aluCtrlD = 3'b101;
          3'b110:  aluCtrlD = 3'b011;
          3'b111:  aluCtrlD = 3'b010;
          default: aluCtrlD = 3'b000;
        endcase
      end
      default: aluCtrlD = 3'b000;
    endcase
  end

  logic [XLEN-1:0] immExtD;

  // Immediate generator selected by the main decoder
  always_comb begin
    immExtD = '0;
    case (immSrcD)
      2'b00: immExtD = {{20{instr[31]}}, instr[31:20]};
      2'b01: immExtD = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      2'b10: immExtD = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      2'b11: immExtD = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: immExtD = '0;
    endcase
  end

  logic killD;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegalD;

  // Unknown opcode, or an ALU funct3 the ALU decoder cannot map
  always_comb begin
    illegalD = 1'b1;
    case (opcode)
      OpR, OpIAlu: illegalD = !(funct3 == 3'b000 || funct3 == 3'b010 ||
                                funct3 == 3'b110 || funct3 == 3'b111);
      OpLw, OpSw, OpBeq, OpJal: illegalD = 1'b0;
      default: illegalD = 1'b1;
    endcase
  end

  assign killD = illegalD;
`else
  assign killD = 1'b0;
`endif

  // ID/EX register: reloads every cycle, loads a zero bubble on FlushE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.RegWriteE   <= 1'b0;
      bus.ResultSrcE  <= 2'b00;
      bus.MemWriteE   <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.ALUControlE <= 3'b000;
      bus.ALUSrcE     <= 1'b0;
      bus.RD1E        <= '0;
      bus.RD2E        <= '0;
      bus.ImmExtE     <= '0;
      bus.RdE         <= 5'd0;
      bus.Rs1E        <= 5'd0;
      bus.Rs2E        <= 5'd0;
      bus.PCE         <= '0;
      bus.PCPlus4E    <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      bus.IllegalE    <= 1'b0;
`endif
    end else if (bus.FlushE) begin
      bus.RegWriteE   <= 1'b0;
      bus.ResultSrcE  <= 2'b00;
      bus.MemWriteE   <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.ALUControlE <= 3'b000;
      bus.ALUSrcE     <= 1'b0;
      bus.RD1E        <= '0;
      bus.RD2E        <= '0;
      bus.ImmExtE     <= '0;
      bus.RdE         <= 5'd0;
      bus.Rs1E        <= 5'd0;
      bus.Rs2E        <= 5'd0;
      bus.PCE         <= '0;
      bus.PCPlus4E    <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      bus.IllegalE    <= 1'b0;
`endif
    end else begin
      bus.RegWriteE   <= regWriteD & ~killD;
      bus.ResultSrcE  <= killD ? 2'b00 : resultSrcD;
      bus.MemWriteE   <= memWriteD & ~killD;
      bus.JumpE       <= jumpD & ~killD;
      bus.BranchE     <= branchD & ~killD;
      bus.ALUControlE <= killD ? 3'b000 : aluCtrlD;
      bus.ALUSrcE     <= aluSrcD & ~killD;
      bus.RD1E        <= rd1;
      bus.RD2E        <= rd2;
      bus.ImmExtE     <= immExtD;
      bus.RdE         <= rd;
      bus.Rs1E        <= rs1;
      bus.Rs2E        <= rs2;
      bus.PCE         <= bus.PCD;
      bus.PCPlus4E    <= bus.PCPlus4D;
`ifdef DECODE_ILLEGAL_TRAP_EN
      bus.IllegalE    <= illegalD;
`endif
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: hand-encoded RV32I instructions with
// hand-computed ID/EX contents, writeback/bypass, flush and reset cases.
module tb_decode_cycle;

  logic clk;
  logic rst;
  int   nChecks;
  int   nPass;

  decode_cycle_if #(.XLEN(32)) bus ();

  decode_cycle #(.XLEN(32), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench
  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drive decode inputs for the coming edge
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic regW, input logic [4:0] rdw,
                       input logic [31:0] result, input logic flush);
    bus.InstrD    = instr;
    bus.PCD       = pc;
    bus.PCPlus4D  = pc + 32'd4;
    bus.RegWriteW = regW;
    bus.RDW       = rdw;
    bus.ResultW   = result;
    bus.FlushE    = flush;
  endtask

  // Advance one edge and sample 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Control bits packed as {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
  function automatic logic [31:0] ctlVec();
    return {22'd0, bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE,
            bus.BranchE, bus.ALUControlE, bus.ALUSrcE};
  endfunction

  task automatic checkZeroE(input string tag);
    checkVal({tag, ".ctl"}, ctlVec(), 32'd0);
    checkVal({tag, ".rd1"}, bus.RD1E, 32'd0);
    checkVal({tag, ".rd2"}, bus.RD2E, 32'd0);
    checkVal({tag, ".imm"}, bus.ImmExtE, 32'd0);
    checkVal({tag, ".regs"}, {17'd0, bus.RdE, bus.Rs1E, bus.Rs2E}, 32'd0);
    checkVal({tag, ".pc"}, bus.PCE, 32'd0);
    checkVal({tag, ".pc4"}, bus.PCPlus4E, 32'd0);
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    rst     = 1'b0;
    drive(32'h0000_0000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    step();
    checkZeroE("reset");

    rst = 1'b1;

    // add x1,x5,x0 while x5 is written the same cycle: bypass
    drive(32'h0002_80B3, 32'h100, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    #1;
    checkVal("add.rs1d", {27'd0, bus.Rs1D}, 32'd5);
    checkVal("add.rs2d", {27'd0, bus.Rs2D}, 32'd0);
    step();
    checkVal("add.rd1_bypass", bus.RD1E, 32'hDEAD_BEEF);
    checkVal("add.rd2", bus.RD2E, 32'd0);
    checkVal("add.rdE", {27'd0, bus.RdE}, 32'd1);
    checkVal("add.rs1E", {27'd0, bus.Rs1E}, 32'd5);
    // RegWrite=1, ResultSrc=00, ALU=000, ALUSrc=0
    checkVal("add.ctl", ctlVec(), 32'b10_0000_0000);
    checkVal("add.pc", bus.PCE, 32'h100);

    // Same instruction, no writeback: value now comes from the array
    drive(32'h0002_80B3, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("add.rd1_rf", bus.RD1E, 32'hDEAD_BEEF);

    // lw x2,-4(x3)
    drive(32'hFFC1_A103, 32'h108, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("lw.imm", bus.ImmExtE, 32'hFFFF_FFFC);
    checkVal("lw.ctl", ctlVec(), 32'b10_1000_0001);
    checkVal("lw.rdE", {27'd0, bus.RdE}, 32'd2);
    checkVal("lw.rs1E", {27'd0, bus.Rs1E}, 32'd3);

    // sw x5,8(x2)
    drive(32'h0051_2423, 32'h10C, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("sw.imm", bus.ImmExtE, 32'd8);
    checkVal("sw.ctl", ctlVec(), 32'b00_0100_0001);
    checkVal("sw.rd2", bus.RD2E, 32'hDEAD_BEEF);
    checkVal("sw.rd1", bus.RD1E, 32'd0);

    // beq x0,x0,-8
    drive(32'hFE00_0CE3, 32'h110, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("beq.imm", bus.ImmExtE, 32'hFFFF_FFF8);
    checkVal("beq.ctl", ctlVec(), 32'b00_0001_0010);

    // sub x3,x5,x5
    drive(32'h4052_81B3, 32'h114, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("sub.ctl", ctlVec(), 32'b10_0000_0010);
    checkVal("sub.rd2", bus.RD2E, 32'hDEAD_BEEF);

    // slti x4,x0,-1
    drive(32'hFFF0_2213, 32'h118, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("slti.ctl", ctlVec(), 32'b10_0000_1011);
    checkVal("slti.imm", bus.ImmExtE, 32'hFFFF_FFFF);

    // or x6,x5,x0
    drive(32'h0002_E333, 32'h11C, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("or.ctl", ctlVec(), 32'b10_0000_0110);

    // jal x1,16
    drive(32'h0100_00EF, 32'h120, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("jal.ctl", ctlVec(), 32'b11_0010_0000);
    checkVal("jal.imm", bus.ImmExtE, 32'd16);
    checkVal("jal.pc4", bus.PCPlus4E, 32'h124);

    // Unsupported opcode (fence): controls zero, fields still pass through
    drive(32'h0000_0F8F, 32'h124, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("unk.ctl", ctlVec(), 32'd0);
    checkVal("unk.rdE", {27'd0, bus.RdE}, 32'd31);
`ifdef DECODE_ILLEGAL_TRAP_EN
    checkVal("unk.illegal", {31'd0, bus.IllegalE}, 32'd1);
`endif

    // Flush bubble while x7 is written
    drive(32'h0002_80B3, 32'h128, 1'b1, 5'd7, 32'h0000_55AA, 1'b1);
    step();
    checkZeroE("flush");

    // add x1,x7,x0: the flushed-cycle write must have landed
    drive(32'h0003_80B3, 32'h12C, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("flush.wr_landed", bus.RD1E, 32'h0000_55AA);

    // Write to x0 is ignored, both same-cycle and afterwards
    drive(32'h0000_00B3, 32'h40, 1'b1, 5'd0, 32'h0000_1234, 1'b0);
    step();
    checkVal("x0.bypass", bus.RD1E, 32'd0);
    checkVal("x0.pc", bus.PCE, 32'h40);
    checkVal("x0.pc4", bus.PCPlus4E, 32'h44);
    drive(32'h0000_00B3, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("x0.read", bus.RD1E, 32'd0);

    // Mid-run async reset: outputs clear without an edge, RF cleared
    drive(32'h0002_80B3, 32'h48, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    checkVal("prerst.rd1", bus.RD1E, 32'hDEAD_BEEF);
    #2;
    rst = 1'b0;
    #1;
    checkZeroE("midrst");
    step();
    rst = 1'b1;
    step();
    checkVal("postrst.x5", bus.RD1E, 32'd0);
    checkVal("postrst.rs1E", {27'd0, bus.Rs1E}, 32'd5);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
